leaky_event_gen: RTL
====================

// Module: leaky_event_gen
// PURPOSE
//  Inverse of the leaky accumulator: turns a target trace level into a stream of event pulses.
//  Holds an internal replica trace that follows the same law as the accumulator:
//   - +(2^W-1) per emitted event
//   - -1 per idle cycle, floored at 0
//  Emits an event whenever the replica is below the target, so a downstream leaky accumulator
//  tracks the target. Used as a stimulus source and as a level-to-spike encoder in the event path.
// PARAMETERS
//  p_base_width  6   W; event increment INC = 2^W-1; trace width W+3
//  p_refrac      4   refractory cycles after each event (>=1)
//  p_cnt_width   16  width of the emitted-event counter
// PORTS
//  i_clk     in   1      clock, rising edge
//  i_rst_n   in   1      asynchronous active-low reset
//  i_en      in   1      generation enable
//  i_target  in   W+3    target trace level (unsigned)
//  i_cnt_clr in   1      synchronous clear of o_count
//  o_event   out  1      one-cycle event pulse, registered
//  o_busy    out  1      high while in REFRACT
//  o_trace   out  W+3    replica trace value
//  o_count   out  p_cnt_width  emitted-event count, saturating
// BEHAVIOUR
//  Reset (async): state IDLE, o_event=0, o_busy=0, o_trace=0, o_count=0, refractory counter=0.
//  Target clamp: T = min(i_target, TMAX), where TMAX = 2^(W+3)-1-INC.
//   - Guarantees trace+INC never wraps.
//   - i_target is sampled combinationally in every TRACK cycle (no latching).
//  States:
//   IDLE:
//    - o_event=0; trace leaks (-1 if >0).
//    - i_en=1 -> TRACK next cycle (the IDLE cycle itself leaks; no emit).
//   TRACK:
//    - i_en=0 -> IDLE, trace leaks, no emit.
//    - else if trace < T: emit. On that edge o_event=1, trace<=trace+INC (no leak this cycle),
//      refractory counter<=p_refrac, state REFRACT, and o_count increments (holds at max).
//    - else: trace leaks, stay in TRACK.
//   REFRACT:
//    - o_busy=1; trace leaks; counter decrements each cycle.
//    - When the counter is 1, the next state is TRACK if i_en=1, else IDLE.
//    - i_en is ignored until REFRACT ends, which enforces a minimum inter-event spacing.
//  Timing:
//   - o_event is high exactly one cycle per emit. Events are >= p_refrac+1 cycles apart.
//   - Latency from the first TRACK cycle with trace<T to o_event high: 1 clock edge.
//  Edge cases:
//   - trace==T is not below target: no emit.
//   - T=0: never emits.
//   - i_cnt_clr coinciding with an emit: o_count<=0 (the clear wins).
//   - Mid-operation reset: all state returns to reset values immediately; any o_event pulse is cut.
//   - i_target changes during REFRACT take effect in the next TRACK cycle.
// TESTING (W=6, p_refrac=4, clock edges counted from the IDLE->TRACK transition)
//  1 Reset, i_en=0 for 20 cycles
//    -> o_event=0, o_trace=0, o_count=0, o_busy=0 throughout.
//  2 i_en=1, i_target=100
//    -> emit at edge 1 (trace 63), edges 2..5 trace 62,61,60,59 with o_busy=1,
//       emit at edge 6 (trace 122);
//    -> next emit only at the first TRACK edge after trace falls to 99; o_count=3 at that point.
//  3 i_target=0 with i_en=1 for 50 cycles
//    -> no events; trace stays 0; state stays TRACK.
//  4 i_target=1023 (exceeds TMAX=448)
//    -> clamps to 448; trace never exceeds 448+62; no wrap; events every 5 cycles
//       until trace>=448.
//  5 i_en dropped at edge 3 (during REFRACT)
//    -> REFRACT completes, state goes IDLE at edge 5, trace leaks to 0 with no further events.
//  6 Async reset during REFRACT; also o_count preset near max with i_cnt_clr on an emit edge
//    -> reset: outputs return to reset values with no clock edge needed;
//    -> counter: o_count saturates at 2^16-1 and does not wrap; i_cnt_clr on an emit edge
//       gives o_count=0.

Source files
------------

// File: rtl/leaky_event_gen.sv
// Level-to-spike encoder: emits event pulses so a replica leaky trace follows a target level.
// Latency: one clock edge from a TRACK cycle with trace below target to a registered o_event pulse.
// Backpressure: none; p_refrac-cycle refractory period (i_en ignored) enforces minimum event spacing.
module leaky_event_gen #(
   parameter int p_base_width = 6,
   parameter int p_refrac     = 4,
   parameter int p_cnt_width  = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   input  logic [p_base_width+2:0]   i_target,
   input  logic                      i_cnt_clr,
   output logic                      o_event,
   output logic                      o_busy,
   output logic [p_base_width+2:0]   o_trace,
   output logic [p_cnt_width-1:0]    o_count
);

   localparam int TW = p_base_width + 3;
   localparam int RW = $clog2(p_refrac + 1);

   // Event increment 2^W-1; the clamp keeps trace+INC inside the TW-bit trace.
   localparam logic [TW-1:0]          INC       = TW'((1 << p_base_width) - 1);
   localparam logic [TW-1:0]          TMAX      = {TW{1'b1}} - INC;
   localparam logic [RW-1:0]          REFRAC_LD = RW'(p_refrac);
   localparam logic [p_cnt_width-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_TRACK   = 2'd1,
      S_REFRACT = 2'd2
   } state_t;

   state_t          state;
   logic [RW-1:0]   refr_cnt;
   logic [TW-1:0]   target_clamped;
   logic [TW-1:0]   trace_leaked;
   logic            emit;

   // Clamp the live target, compute the leaked trace and the emit decision for this cycle.
   always_comb begin
      target_clamped = (i_target > TMAX) ? TMAX : i_target;
      trace_leaked   = (o_trace != '0) ? (o_trace - TW'(1)) : '0;
      emit           = (state == S_TRACK) && i_en && (o_trace < target_clamped);
   end

   // Control FSM with replica trace, refractory counter and registered event/busy outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         o_event  <= 1'b0;
         o_busy   <= 1'b0;
         o_trace  <= '0;
         refr_cnt <= '0;
      end else begin
         o_event <= 1'b0;
         case (state)
            S_IDLE: begin
               o_trace <= trace_leaked;
               if (i_en) begin
                  state <= S_TRACK;
               end
            end
            S_TRACK: begin
               if (emit) begin
                  // The emit edge adds the increment instead of leaking.
                  o_event  <= 1'b1;
                  o_busy   <= 1'b1;
                  o_trace  <= o_trace + INC;
                  refr_cnt <= REFRAC_LD;
                  state    <= S_REFRACT;
               end else begin
                  o_trace <= trace_leaked;
                  if (!i_en) begin
                     state <= S_IDLE;
                  end
               end
            end
            S_REFRACT: begin
               o_trace  <= trace_leaked;
               refr_cnt <= refr_cnt - RW'(1);
               if (refr_cnt == RW'(1)) begin
                  o_busy <= 1'b0;
                  state  <= i_en ? S_TRACK : S_IDLE;
               end
            end
            default: begin
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating emitted-event counter; a clear on the same edge as an emit wins.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_count <= '0;
      end else if (i_cnt_clr) begin
         o_count <= '0;
      end else if (emit && (o_count != CNT_MAX)) begin
         o_count <= o_count + p_cnt_width'(1);
      end
   end

endmodule
